// File: rtl/wbq_pkg.sv
// Shared types and helpers for the register-file writeback queue.
package wbq_pkg;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam logic [AW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wbq_entry_t;

    // Free slots visible to producers this cycle; the head pop frees one in the same edge.
    function automatic int wbq_space(input int count, input int depth);
        return depth - count + ((count != 0) ? 1 : 0);
    endfunction
endpackage

// File: rtl/regfile_writeback_queue_if.sv
// Producer handshakes, regfile write port and bypass lookups of the writeback queue.
interface regfile_writeback_queue_if
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          LdValid;
    logic          LdReady;
    logic [AW-1:0] LdReg;
    logic [DW-1:0] LdData;
    logic          AluValid;
    logic          AluReady;
    logic [AW-1:0] AluReg;
    logic [DW-1:0] AluData;
    logic          RegWrite;
    logic [AW-1:0] WriteRegister;
    logic [DW-1:0] WriteData;
    logic [AW-1:0] ReadRegister1;
    logic [AW-1:0] ReadRegister2;
    logic          BypassHit1;
    logic [DW-1:0] BypassData1;
    logic          BypassHit2;
    logic [DW-1:0] BypassData2;
    logic [CW-1:0] Pending;

    modport slave (
        input  LdValid, LdReg, LdData, AluValid, AluReg, AluData,
               ReadRegister1, ReadRegister2,
        output LdReady, AluReady, RegWrite, WriteRegister, WriteData,
               BypassHit1, BypassData1, BypassHit2, BypassData2, Pending
    );

    modport master (
        output LdValid, LdReg, LdData, AluValid, AluReg, AluData,
               ReadRegister1, ReadRegister2,
        input  LdReady, AluReady, RegWrite, WriteRegister, WriteData,
               BypassHit1, BypassData1, BypassHit2, BypassData2, Pending
    );
endinterface

// File: rtl/wbq_bypass_lookup.sv
// Age-ordered CAM over the live queue window; the youngest matching entry wins.
module wbq_bypass_lookup
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  wbq_entry_t [DEPTH-1:0] entries,
    input  logic [PW-1:0]          head,
    input  logic [CW-1:0]          count,
    input  logic [AW-1:0]          addr,
    output logic                   hit,
    output logic [DW-1:0]          data
);
    always_comb begin
        logic [PW-1:0] idx;
        hit  = 1'b0;
        data = '0;
        idx  = head;
        // Walk oldest to youngest so a later match overrides an earlier one.
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (addr != ZERO_REG) && (entries[idx].rd == addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end
endmodule

// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue feeding the regfile's single write port from load and ALU producers.
// Define WBQ_BYPASS_EN to build the youngest-match bypass lookups; otherwise bypass outputs tie to 0.
module regfile_writeback_queue
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    regfile_writeback_queue_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wbq_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]          head;
    logic [PW-1:0]          tail;
    logic [CW-1:0]          count;

    int   space;
    logic ld_ready;
    logic alu_ready;
    logic ld_push;
    logic alu_push;
    logic pop;

    always_comb begin
        space     = wbq_space(int'(count), DEPTH);
        pop       = (count != '0);
        ld_ready  = !Reset && (space >= 1);
        // Load is older: a valid load claims a slot before the ALU may.
        alu_ready = !Reset && ((bus.LdValid && ld_ready) ? (space >= 2) : (space >= 1));
        ld_push   = bus.LdValid && ld_ready && (bus.LdReg != ZERO_REG);
        alu_push  = bus.AluValid && alu_ready && (bus.AluReg != ZERO_REG);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (ld_push)
                mem[tail] <= '{rd: bus.LdReg, data: bus.LdData};
            if (alu_push)
                mem[tail + PW'(ld_push)] <= '{rd: bus.AluReg, data: bus.AluData};
            head  <= head + PW'(pop);
            tail  <= tail + PW'(ld_push) + PW'(alu_push);
            count <= count + CW'(ld_push) + CW'(alu_push) - CW'(pop);
        end
    end

    assign bus.LdReady       = ld_ready;
    assign bus.AluReady      = alu_ready;
    assign bus.RegWrite      = !Reset && pop;
    assign bus.WriteRegister = (!Reset && pop) ? mem[head].rd   : '0;
    assign bus.WriteData     = (!Reset && pop) ? mem[head].data : '0;
    assign bus.Pending       = count;

`ifdef WBQ_BYPASS_EN
    logic          hit1;
    logic          hit2;
    logic [DW-1:0] data1;
    logic [DW-1:0] data2;

    wbq_bypass_lookup #(.DEPTH(DEPTH)) u_lookup1 (
        .entries (mem),
        .head    (head),
        .count   (count),
        .addr    (bus.ReadRegister1),
        .hit     (hit1),
        .data    (data1)
    );

    wbq_bypass_lookup #(.DEPTH(DEPTH)) u_lookup2 (
        .entries (mem),
        .head    (head),
        .count   (count),
        .addr    (bus.ReadRegister2),
        .hit     (hit2),
        .data    (data2)
    );

    assign bus.BypassHit1  = !Reset && hit1;
    assign bus.BypassData1 = Reset ? '0 : data1;
    assign bus.BypassHit2  = !Reset && hit2;
    assign bus.BypassData2 = Reset ? '0 : data2;
`else
    assign bus.BypassHit1  = 1'b0;
    assign bus.BypassData1 = '0;
    assign bus.BypassHit2  = 1'b0;
    assign bus.BypassData2 = '0;
`endif
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: inputs change at negedge, outputs sampled 1ns later.
module tb_regfile_writeback_queue;
    logic Clk;
    logic Reset;
    int   vectors;
    int   miscompares;

    regfile_writeback_queue_if #(.DEPTH(4)) bus ();

    regfile_writeback_queue #(.DEPTH(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic idle_inputs();
        bus.LdValid = 1'b0; bus.LdReg = '0; bus.LdData = '0;
        bus.AluValid = 1'b0; bus.AluReg = '0; bus.AluData = '0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        idle_inputs();
        bus.ReadRegister1 = 5'd9; bus.ReadRegister2 = 5'd0;
        bus.LdValid = 1'b1; bus.LdReg = 5'd9; bus.LdData = 32'h9;
        bus.AluValid = 1'b1; bus.AluReg = 5'd10; bus.AluData = 32'hA;
        repeat (2) @(posedge Clk);
        @(negedge Clk); #1;
        vectors++; if (bus.LdReady !== 1'b0) begin miscompares++; $display("FAIL reset ld_ready got %b exp 0", bus.LdReady); end
        vectors++; if (bus.AluReady !== 1'b0) begin miscompares++; $display("FAIL reset alu_ready got %b exp 0", bus.AluReady); end
        vectors++; if (bus.RegWrite !== 1'b0) begin miscompares++; $display("FAIL reset regwrite got %b exp 0", bus.RegWrite); end
        vectors++; if (bus.WriteRegister !== 5'd0) begin miscompares++; $display("FAIL reset write_reg got %0d exp 0", bus.WriteRegister); end
        vectors++; if (bus.Pending !== 3'd0) begin miscompares++; $display("FAIL reset pending got %0d exp 0", bus.Pending); end
        vectors++; if (bus.BypassHit1 !== 1'b0) begin miscompares++; $display("FAIL reset hit1 got %b exp 0", bus.BypassHit1); end
        Reset = 1'b0;
        idle_inputs();
        bus.ReadRegister1 = 5'd0;
        @(negedge Clk); #1;
        vectors++; if (bus.Pending !== 3'd0) begin miscompares++; $display("FAIL reset_release pending got %0d exp 0", bus.Pending); end
        @(negedge Clk);
    endtask

    task automatic test_single_load();
        bus.LdValid = 1'b1; bus.LdReg = 5'd5; bus.LdData = 32'hAAAA0005;
        #1;
        vectors++; if (bus.LdReady !== 1'b1) begin miscompares++; $display("FAIL single ld_ready got %b exp 1", bus.LdReady); end
        vectors++; if (bus.RegWrite !== 1'b0) begin miscompares++; $display("FAIL single early_regwrite got %b exp 0", bus.RegWrite); end
        @(negedge Clk);
        idle_inputs(); #1;
        vectors++; if (bus.RegWrite !== 1'b1) begin miscompares++; $display("FAIL single regwrite got %b exp 1", bus.RegWrite); end
        vectors++; if (bus.WriteRegister !== 5'd5) begin miscompares++; $display("FAIL single write_reg got %0d exp 5", bus.WriteRegister); end
        vectors++; if (bus.WriteData !== 32'hAAAA0005) begin miscompares++; $display("FAIL single write_data got %h exp aaaa0005", bus.WriteData); end
        vectors++; if (bus.Pending !== 3'd1) begin miscompares++; $display("FAIL single pending got %0d exp 1", bus.Pending); end
        @(negedge Clk); #1;
        vectors++; if (bus.Pending !== 3'd0) begin miscompares++; $display("FAIL single drained pending got %0d exp 0", bus.Pending); end
        vectors++; if (bus.RegWrite !== 1'b0) begin miscompares++; $display("FAIL single drained regwrite got %b exp 0", bus.RegWrite); end
        @(negedge Clk);
    endtask

    task automatic test_dual_accept();
        bus.LdValid = 1'b1; bus.LdReg = 5'd3; bus.LdData = 32'h33;
        bus.AluValid = 1'b1; bus.AluReg = 5'd4; bus.AluData = 32'h44;
        #1;
        vectors++; if (bus.LdReady !== 1'b1) begin miscompares++; $display("FAIL dual ld_ready got %b exp 1", bus.LdReady); end
        vectors++; if (bus.AluReady !== 1'b1) begin miscompares++; $display("FAIL dual alu_ready got %b exp 1", bus.AluReady); end
        @(negedge Clk);
        idle_inputs(); #1;
        vectors++; if (bus.Pending !== 3'd2) begin miscompares++; $display("FAIL dual pending got %0d exp 2", bus.Pending); end
        vectors++; if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd3 || bus.WriteData !== 32'h33)
            begin miscompares++; $display("FAIL dual first_write got %b/%0d/%h exp 1/3/33", bus.RegWrite, bus.WriteRegister, bus.WriteData); end
        @(negedge Clk); #1;
        vectors++; if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd4 || bus.WriteData !== 32'h44)
            begin miscompares++; $display("FAIL dual second_write got %b/%0d/%h exp 1/4/44", bus.RegWrite, bus.WriteRegister, bus.WriteData); end
        @(negedge Clk); #1;
        vectors++; if (bus.Pending !== 3'd0) begin miscompares++; $display("FAIL dual drained pending got %0d exp 0", bus.Pending); end
        @(negedge Clk);
    endtask

    task automatic test_back_to_back();
        int          pend_exp [15] = '{0, 2, 3, 4, 4, 4, 4, 4, 4, 4, 4, 3, 2, 1, 0};
        int          wr_reg   [13] = '{16, 1, 17, 2, 18, 3, 19, 20, 4, 5, 6, 7, 8};
        logic [31:0] wr_data  [13] = '{32'h1000, 32'h2001, 32'h1001, 32'h2002, 32'h1002, 32'h2003,
                                       32'h1003, 32'h1004, 32'h2004, 32'h2005, 32'h2006, 32'h2007, 32'h2008};
        int   aidx = 1;
        logic alu_exp;
        for (int c = 0; c < 15; c++) begin
            bus.LdValid  = (c < 5);
            bus.LdReg    = 5'(16 + c);
            bus.LdData   = 32'(32'h1000 + c);
            bus.AluValid = (aidx <= 8);
            bus.AluReg   = 5'(aidx);
            bus.AluData  = 32'(32'h2000 + aidx);
            #1;
            alu_exp = !(c == 3 || c == 4);
            vectors++; if (int'(bus.Pending) !== pend_exp[c])
                begin miscompares++; $display("FAIL b2b pending cycle %0d got %0d exp %0d", c, bus.Pending, pend_exp[c]); end
            if (c < 10) begin
                vectors++; if (bus.AluReady !== alu_exp)
                    begin miscompares++; $display("FAIL b2b alu_ready cycle %0d got %b exp %b", c, bus.AluReady, alu_exp); end
            end
            if (c >= 1 && c <= 13) begin
                vectors++; if (bus.RegWrite !== 1'b1 || int'(bus.WriteRegister) !== wr_reg[c-1] || bus.WriteData !== wr_data[c-1])
                    begin miscompares++; $display("FAIL b2b write cycle %0d got %b/%0d/%h exp 1/%0d/%h", c, bus.RegWrite, bus.WriteRegister, bus.WriteData, wr_reg[c-1], wr_data[c-1]); end
            end else begin
                vectors++; if (bus.RegWrite !== 1'b0)
                    begin miscompares++; $display("FAIL b2b idle_regwrite cycle %0d got %b exp 0", c, bus.RegWrite); end
            end
            if (alu_exp && aidx <= 8) aidx++;
            @(negedge Clk);
        end
        idle_inputs();
    endtask

    task automatic test_reg_zero();
        bus.LdValid = 1'b1; bus.LdReg = 5'd0; bus.LdData = 32'hDEAD;
        #1;
        vectors++; if (bus.LdReady !== 1'b1) begin miscompares++; $display("FAIL r0 ld_ready got %b exp 1", bus.LdReady); end
        @(negedge Clk);
        idle_inputs(); #1;
        vectors++; if (bus.Pending !== 3'd0) begin miscompares++; $display("FAIL r0 pending got %0d exp 0", bus.Pending); end
        vectors++; if (bus.RegWrite !== 1'b0) begin miscompares++; $display("FAIL r0 regwrite got %b exp 0", bus.RegWrite); end
        // A dropped r0 load must not leave a hole ahead of the ALU result.
        bus.LdValid = 1'b1; bus.LdReg = 5'd0; bus.LdData = 32'hDEAD;
        bus.AluValid = 1'b1; bus.AluReg = 5'd6; bus.AluData = 32'h66;
        #1;
        vectors++; if (bus.AluReady !== 1'b1) begin miscompares++; $display("FAIL r0 alu_ready got %b exp 1", bus.AluReady); end
        @(negedge Clk);
        idle_inputs(); #1;
        vectors++; if (bus.Pending !== 3'd1) begin miscompares++; $display("FAIL r0_alu pending got %0d exp 1", bus.Pending); end
        vectors++; if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd6 || bus.WriteData !== 32'h66)
            begin miscompares++; $display("FAIL r0_alu write got %b/%0d/%h exp 1/6/66", bus.RegWrite, bus.WriteRegister, bus.WriteData); end
        @(negedge Clk); #1;
        vectors++; if (bus.Pending !== 3'd0) begin miscompares++; $display("FAIL r0_alu drained pending got %0d exp 0", bus.Pending); end
        @(negedge Clk);
    endtask

    task automatic test_bypass();
        bus.LdValid = 1'b1; bus.LdReg = 5'd7; bus.LdData = 32'h1;
        bus.AluValid = 1'b1; bus.AluReg = 5'd7; bus.AluData = 32'h2;
        bus.ReadRegister1 = 5'd7; bus.ReadRegister2 = 5'd0;
        #1;
        vectors++; if (bus.BypassHit1 !== 1'b0) begin miscompares++; $display("FAIL bypass same_cycle hit1 got %b exp 0", bus.BypassHit1); end
        @(negedge Clk);
        idle_inputs(); #1;
        vectors++; if (bus.WriteData !== 32'h1) begin miscompares++; $display("FAIL bypass head_data got %h exp 1", bus.WriteData); end
`ifdef WBQ_BYPASS_EN
        vectors++; if (bus.BypassHit1 !== 1'b1 || bus.BypassData1 !== 32'h2)
            begin miscompares++; $display("FAIL bypass youngest got %b/%h exp 1/2", bus.BypassHit1, bus.BypassData1); end
        vectors++; if (bus.BypassHit2 !== 1'b0) begin miscompares++; $display("FAIL bypass r0 hit2 got %b exp 0", bus.BypassHit2); end
`else
        vectors++; if (bus.BypassHit1 !== 1'b0 || bus.BypassData1 !== 32'h0)
            begin miscompares++; $display("FAIL bypass disabled got %b/%h exp 0/0", bus.BypassHit1, bus.BypassData1); end
`endif
        @(negedge Clk);
        bus.ReadRegister2 = 5'd7; #1;
`ifdef WBQ_BYPASS_EN
        vectors++; if (bus.BypassHit1 !== 1'b1 || bus.BypassData1 !== 32'h2)
            begin miscompares++; $display("FAIL bypass head_only got %b/%h exp 1/2", bus.BypassHit1, bus.BypassData1); end
        vectors++; if (bus.BypassHit2 !== 1'b1 || bus.BypassData2 !== 32'h2)
            begin miscompares++; $display("FAIL bypass port2 got %b/%h exp 1/2", bus.BypassHit2, bus.BypassData2); end
`else
        vectors++; if (bus.BypassHit2 !== 1'b0) begin miscompares++; $display("FAIL bypass disabled hit2 got %b exp 0", bus.BypassHit2); end
`endif
        @(negedge Clk); #1;
        vectors++; if (bus.BypassHit1 !== 1'b0 || bus.BypassHit2 !== 1'b0)
            begin miscompares++; $display("FAIL bypass drained got %b/%b exp 0/0", bus.BypassHit1, bus.BypassHit2); end
        bus.ReadRegister1 = 5'd0; bus.ReadRegister2 = 5'd0;
        @(negedge Clk);
    endtask

    task automatic test_reset_mid();
        bus.LdValid = 1'b1; bus.LdReg = 5'd11; bus.LdData = 32'hB;
        bus.AluValid = 1'b1; bus.AluReg = 5'd12; bus.AluData = 32'hC;
        @(negedge Clk);
        bus.LdReg = 5'd13; bus.LdData = 32'hD;
        bus.AluReg = 5'd14; bus.AluData = 32'hE;
        #1;
        vectors++; if (bus.AluReady !== 1'b1) begin miscompares++; $display("FAIL midreset alu_ready got %b exp 1", bus.AluReady); end
        @(negedge Clk);
        idle_inputs(); #1;
        vectors++; if (bus.Pending !== 3'd3) begin miscompares++; $display("FAIL midreset pending_before got %0d exp 3", bus.Pending); end
        Reset = 1'b1; #1;
        vectors++; if (bus.RegWrite !== 1'b0 || bus.WriteRegister !== 5'd0)
            begin miscompares++; $display("FAIL midreset forced_write got %b/%0d exp 0/0", bus.RegWrite, bus.WriteRegister); end
        vectors++; if (bus.LdReady !== 1'b0) begin miscompares++; $display("FAIL midreset ld_ready got %b exp 0", bus.LdReady); end
        @(negedge Clk);
        Reset = 1'b0; #1;
        vectors++; if (bus.Pending !== 3'd0) begin miscompares++; $display("FAIL midreset pending_after got %0d exp 0", bus.Pending); end
        for (int c = 0; c < 3; c++) begin
            vectors++; if (bus.RegWrite !== 1'b0)
                begin miscompares++; $display("FAIL midreset stale_write cycle %0d got %b/%0d exp 0", c, bus.RegWrite, bus.WriteRegister); end
            @(negedge Clk); #1;
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_single_load();
        test_dual_accept();
        test_back_to_back();
        test_reg_zero();
        test_bypass();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
